// File: rtl/firmware_config_sequencer.sv
// firmware_config_sequencer
// Owns the tracing/configId/configData nets that feed the datapath blocks.
// A host command stops tracing and drains the pipeline while the firmware
// image for one block is buffered. The image is then replayed as a single
// gap-free burst, followed by one configId=0 cycle that clears every block's
// byte counter.
// Optional build macro: CFG_CHECKSUM_EN. When defined, the image carries one
// trailing checksum byte (8-bit wrap-around sum of the payload). A mismatch
// skips the burst and reports err in the GAP cycle.
module firmware_config_sequencer #(
  parameter int NUM_BLOCKS      = 8,
  parameter int BYTES_PER_BLOCK = 24,
  parameter int DRAIN_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trace_en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_block_id,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_data,
  output logic       tracing,
  output logic [7:0] configId,
  output logic [7:0] configData,
  output logic       busy,
  output logic       done,
  output logic       err
);

`ifdef CFG_CHECKSUM_EN
  localparam int BYTES_IN = BYTES_PER_BLOCK + 1;
`else
  localparam int BYTES_IN = BYTES_PER_BLOCK;
`endif
  localparam int CNT_W = $clog2(BYTES_IN + 1);
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] IN_FULL  = CNT_W'(BYTES_IN);
  localparam logic [CNT_W-1:0] PAYLOAD  = CNT_W'(BYTES_PER_BLOCK);
  localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);
  localparam logic [DRN_W-1:0] DRN_ZERO = DRN_W'(0);
  localparam logic [DRN_W-1:0] DRN_MAX  = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [7:0]       MAX_ID   = 8'(NUM_BLOCKS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRACE = 3'd1,
    S_DRAIN = 3'd2,
    S_BURST = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] burst_idx_q, burst_idx_d;
  logic [7:0]       id_q, id_d;
`ifdef CFG_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
  logic             cks_ok_q, cks_ok_d;
`endif

  logic             tracing_q, tracing_d;
  logic [7:0]       config_id_q, config_id_d;
  logic [7:0]       config_data_q, config_data_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [7:0]       img_q [0:BYTES_PER_BLOCK-1];

  logic             cmd_fire_s;
  logic             cfg_fire_s;
  logic             id_ok_s;
  logic             img_we_s;

  // Handshake qualifiers: the registered ready flags decide acceptance.
  always_comb begin
    cmd_fire_s = cmd_valid & cmd_ready_q;
    cfg_fire_s = cfg_valid & cfg_ready_q;
    id_ok_s    = (cmd_block_id != 8'h00) && (cmd_block_id <= MAX_ID);
    img_we_s   = cfg_fire_s && (byte_cnt_q < PAYLOAD);
  end

  // Next-state and next-output logic; all outputs are derived from state_d
  // so a transition and its outputs appear together after the same edge.
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    byte_cnt_d    = byte_cnt_q;
    burst_idx_d   = burst_idx_q;
    id_d          = id_q;
`ifdef CFG_CHECKSUM_EN
    sum_d         = sum_q;
    cks_ok_d      = cks_ok_q;
`endif
    config_id_d   = 8'h00;
    config_data_d = 8'h00;
    done_d        = 1'b0;
    err_d         = 1'b0;

    case (state_q)
      S_IDLE, S_TRACE: begin
        if (cmd_fire_s) begin
          // Any consumed command restarts the image bookkeeping.
          drain_d     = DRN_ZERO;
          byte_cnt_d  = CNT_ZERO;
          burst_idx_d = CNT_ZERO;
`ifdef CFG_CHECKSUM_EN
          sum_d       = 8'h00;
          cks_ok_d    = 1'b0;
`endif
          if (id_ok_s) begin
            state_d = S_DRAIN;
            id_d    = cmd_block_id;
          end else begin
            err_d   = 1'b1;
          end
        end else if (state_q == S_IDLE) begin
          if (trace_en && !cmd_valid) begin
            state_d = S_TRACE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (!trace_en) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_TRACE;
          end
        end
      end

      S_DRAIN: begin
        // Drain timer saturates so a slow image fill keeps it at its max.
        if (drain_q != DRN_MAX) begin
          drain_d = drain_q + DRN_ONE;
        end else begin
          drain_d = drain_q;
        end
        if (cfg_fire_s) begin
          byte_cnt_d = byte_cnt_q + CNT_ONE;
`ifdef CFG_CHECKSUM_EN
          if (byte_cnt_q < PAYLOAD) begin
            sum_d = sum_q + cfg_data;
          end else begin
            cks_ok_d = (cfg_data == sum_q);
          end
`endif
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
        if ((drain_q == DRN_MAX) && (byte_cnt_q == IN_FULL)) begin
`ifdef CFG_CHECKSUM_EN
          if (cks_ok_q) begin
            state_d       = S_BURST;
            config_id_d   = id_q;
            config_data_d = img_q[0];
            burst_idx_d   = CNT_ONE;
          end else begin
            state_d = S_GAP;
            err_d   = 1'b1;
          end
`else
          state_d       = S_BURST;
          config_id_d   = id_q;
          config_data_d = img_q[0];
          burst_idx_d   = CNT_ONE;
`endif
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_BURST: begin
        if (burst_idx_q == PAYLOAD) begin
          state_d = S_GAP;
          done_d  = 1'b1;
        end else begin
          config_id_d   = id_q;
          config_data_d = img_q[burst_idx_q];
          burst_idx_d   = burst_idx_q + CNT_ONE;
        end
      end

      S_GAP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    tracing_d   = (state_d == S_TRACE);
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_TRACE);
    busy_d      = !((state_d == S_IDLE) || (state_d == S_TRACE));
    cfg_ready_d = (state_d == S_DRAIN) && (byte_cnt_d < IN_FULL);
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      drain_q       <= DRN_ZERO;
      byte_cnt_q    <= CNT_ZERO;
      burst_idx_q   <= CNT_ZERO;
      id_q          <= 8'h00;
`ifdef CFG_CHECKSUM_EN
      sum_q         <= 8'h00;
      cks_ok_q      <= 1'b0;
`endif
      tracing_q     <= 1'b0;
      config_id_q   <= 8'h00;
      config_data_q <= 8'h00;
      cmd_ready_q   <= 1'b0;
      cfg_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      byte_cnt_q    <= byte_cnt_d;
      burst_idx_q   <= burst_idx_d;
      id_q          <= id_d;
`ifdef CFG_CHECKSUM_EN
      sum_q         <= sum_d;
      cks_ok_q      <= cks_ok_d;
`endif
      tracing_q     <= tracing_d;
      config_id_q   <= config_id_d;
      config_data_q <= config_data_d;
      cmd_ready_q   <= cmd_ready_d;
      cfg_ready_q   <= cfg_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  // Image buffer: payload bytes stored in arrival order, contents need no reset.
  always_ff @(posedge clk) begin
    if (img_we_s) begin
      img_q[byte_cnt_q] <= cfg_data;
    end
  end

  assign tracing    = tracing_q;
  assign configId   = config_id_q;
  assign configData = config_data_q;
  assign cmd_ready  = cmd_ready_q;
  assign cfg_ready  = cfg_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_firmware_config_sequencer.sv
// Directed bench for firmware_config_sequencer: payload bytes are pushed to a
// scoreboard as they are accepted and popped as the burst presents them.
module tb_firmware_config_sequencer;

  localparam int NB = 24;

  logic       clk = 1'b0;
  logic       reset;
  logic       trace_en;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_block_id;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       tracing;
  logic [7:0] configId;
  logic [7:0] configData;
  logic       busy;
  logic       done;
  logic       err;

  int         vecs = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  logic [7:0] sb [$];

  firmware_config_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .trace_en     (trace_en),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_block_id (cmd_block_id),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_data     (cfg_data),
    .tracing      (tracing),
    .configId     (configId),
    .configData   (configData),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command; returns once it has been accepted (or the wait expired).
  task automatic send_cmd(input logic [7:0] id);
    int w;
    w = 0;
    cmd_valid    = 1'b1;
    cmd_block_id = id;
    while (cmd_ready !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    tick();
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  // Send NB payload bytes base+i*step (plus checksum when enabled), gap idle
  // cycles between bytes; payload is pushed to the scoreboard on acceptance.
  task automatic send_image(input logic [7:0] base, input logic [7:0] step,
                            input int gap, input logic [7:0] cks_delta);
    logic [7:0] b;
    logic [7:0] sum;
    int         n;
    int         w;
    sum = 8'h00;
`ifdef CFG_CHECKSUM_EN
    n = NB + 1;
`else
    n = NB;
`endif
    for (int i = 0; i < n; i++) begin
      if (i < NB) begin
        b   = base + 8'(i) * step;
        sum = sum + b;
      end else begin
        b = sum + cks_delta;
      end
      cfg_valid = 1'b1;
      cfg_data  = b;
      w = 0;
      while (cfg_ready !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      check("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
      tick();
      if (i < NB) sb.push_back(b);
      cfg_valid = 1'b0;
      if (i != n - 1) repeat (gap) tick();
    end
  endtask

  // Wait for the burst, then compare every cycle of it plus the GAP cycle.
  task automatic expect_burst(input logic [7:0] id);
    int w;
    logic [7:0] e;
    w = 0;
    while (configId === 8'h00 && w < 60) begin
      tick();
      w++;
    end
    check("burst_start", {31'd0, configId !== 8'h00}, 32'd1);
    check("drain_min", {31'd0, (cyc - acc_cyc) >= 4}, 32'd1);
    for (int k = 0; k < NB; k++) begin
      e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      check("burst_id", {24'd0, configId}, {24'd0, id});
      check("burst_data", {24'd0, configData}, {24'd0, e});
      check("burst_trc_rdy_done", {29'd0, tracing, cfg_ready, done}, 32'd0);
      tick();
    end
    check("gap_id", {24'd0, configId}, 32'd0);
    check("gap_data", {24'd0, configData}, 32'd0);
    check("gap_done", {31'd0, done}, 32'd1);
    check("gap_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    check("post_gap_done", {30'd0, done, tracing}, 32'd0);
    tick();
    check("trace_resume", {31'd0, tracing}, 32'd1);
  endtask

  initial begin
    int w;
    int nz;
    int err_seen;
    int done_seen;
    reset        = 1'b1;
    trace_en     = 1'b1;
    cmd_valid    = 1'b0;
    cmd_block_id = 8'h00;
    cfg_valid    = 1'b0;
    cfg_data     = 8'h00;

    // Reset state
    repeat (3) tick();
    check("rst_outputs", {tracing, cmd_ready, cfg_ready, busy, done, err},
          32'd0);
    check("rst_cfg", {16'd0, configId, configData}, 32'd0);
    reset = 1'b0;
    check("trace_after_release", {31'd0, tracing}, 32'd0);
    tick();
    check("trace_on", {31'd0, tracing}, 32'd1);
    check("trace_id0", {24'd0, configId}, 32'd0);

    // ID 3, full-rate bytes 0x00..0x17
    send_cmd(8'd3);
    check("acc_trace_off", {31'd0, tracing}, 32'd0);
    check("acc_busy_rdy", {29'd0, busy, cmd_ready, cfg_ready}, 32'b101);
    send_image(8'h00, 8'h01, 0, 8'h00);
    check("fill_cfg_ready_drop", {31'd0, cfg_ready}, 32'd0);
    expect_burst(8'd3);

    // ID 5, one byte every 3 cycles, then an excess byte offered
    send_cmd(8'd5);
    send_image(8'h40, 8'h03, 2, 8'h00);
    check("slow_cfg_ready_drop", {31'd0, cfg_ready}, 32'd0);
    cfg_valid = 1'b1;
    cfg_data  = 8'hEE;
    check("slow_no_burst_yet", {24'd0, configId}, 32'd0);
    tick();
    check("slow_burst_next", {24'd0, configId}, 32'd5);
    expect_burst(8'd5);
    cfg_valid = 1'b0;

    // Invalid IDs in TRACE
    cmd_valid    = 1'b1;
    cmd_block_id = 8'd0;
    tick();
    cmd_valid = 1'b0;
    check("id0_err", {28'd0, err, tracing, busy, cmd_ready}, 32'b1101);
    check("id0_cfgid", {24'd0, configId}, 32'd0);
    tick();
    check("id0_err_pulse", {30'd0, err, tracing}, 32'b01);
    cmd_valid    = 1'b1;
    cmd_block_id = 8'd9;
    tick();
    cmd_valid = 1'b0;
    check("id9_err", {28'd0, err, tracing, busy, cmd_ready}, 32'b1101);
    tick();
    check("id9_err_pulse", {30'd0, err, tracing}, 32'b01);
    check("id9_cfgid", {24'd0, configId}, 32'd0);

    // Reset on the 10th burst cycle
    send_cmd(8'd7);
    send_image(8'h80, 8'h01, 0, 8'h00);
    w = 0;
    while (configId === 8'h00 && w < 60) begin
      tick();
      w++;
    end
    check("rb_start", {24'd0, configId}, 32'd7);
    for (int k = 0; k < 9; k++) begin
      check("rb_data", {24'd0, configData}, {24'd0, sb.pop_front()});
      tick();
    end
    check("rb_10th", {24'd0, configId}, 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check("rb_outputs", {29'd0, tracing, busy, configId != 8'h00}, 32'd0);
    check("rb_data0", {24'd0, configData}, 32'd0);
    send_cmd(8'd2);
    send_image(8'hC0, 8'h05, 0, 8'h00);
    expect_burst(8'd2);

`ifdef CFG_CHECKSUM_EN
    // Checksum good: 0x01 x24 with 0x18
    send_cmd(8'd4);
    send_image(8'h01, 8'h00, 0, 8'h00);
    expect_burst(8'd4);
    // Checksum bad: 0x17
    send_cmd(8'd4);
    send_image(8'h01, 8'h00, 0, 8'hFF);
    sb.delete();
    nz = 0;
    err_seen = 0;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (configId !== 8'h00) nz++;
      if (err === 1'b1) err_seen++;
      if (done === 1'b1) done_seen++;
      tick();
    end
    check("cks_bad_no_burst", nz, 32'd0);
    check("cks_bad_err", err_seen, 32'd1);
    check("cks_bad_no_done", done_seen, 32'd0);
`else
    nz = 0;
    err_seen = 0;
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (err === 1'b1) err_seen++;
      if (done === 1'b1) done_seen++;
      tick();
    end
    check("idle_quiet", err_seen + done_seen + nz, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
